// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, FSM encoding and GF(2^8) / ShiftRows helpers.
// Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam logic [1:0] c_keylen_128 = 2'd0;
    localparam logic [1:0] c_keylen_192 = 2'd1;
    localparam logic [1:0] c_keylen_256 = 2'd2;

    localparam logic [3:0] c_nr_128 = 4'd10;
    localparam logic [3:0] c_nr_192 = 4'd12;
    localparam logic [3:0] c_nr_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SBOX  = 2'd1,
        ST_MAIN  = 2'd2,
        ST_FINAL = 2'd3
    } aes_state_t;

    // Reserved keylen code 3 falls back to the AES-128 round count.
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            c_keylen_192: return c_nr_192;
            c_keylen_256: return c_nr_256;
            default:      return c_nr_128;
        endcase
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    // Column c occupies bits [127-32c -: 32]; row r is byte r of that word.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_mixcolumn_word.sv
`default_nettype none
// ============================================================================
// Module      : aes_mixcolumn_word
// Description : Combinational MixColumns of one 32-bit state column.
// Revision    : 1.0  initial release
// ============================================================================
module aes_mixcolumn_word
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_b0, w_b1, w_b2, w_b3;

    assign w_b0 = i_col[31:24];
    assign w_b1 = i_col[23:16];
    assign w_b2 = i_col[15:8];
    assign w_b3 = i_col[7:0];

    assign o_col[31:24] = gm2(w_b0) ^ gm3(w_b1) ^ w_b2      ^ w_b3;
    assign o_col[23:16] = w_b0      ^ gm2(w_b1) ^ gm3(w_b2) ^ w_b3;
    assign o_col[15:8]  = w_b0      ^ w_b1      ^ gm2(w_b2) ^ gm3(w_b3);
    assign o_col[7:0]   = gm3(w_b0) ^ w_b1      ^ w_b2      ^ gm2(w_b3);

endmodule
`default_nettype wire

// File: rtl/aes_encipher_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : aes_encipher_round_engine
// Description : Iterative AES-128/192/256 encipher datapath with a
//               configurable number of external S-box lanes.
// Revision    : 1.0  initial release
// ============================================================================
module aes_encipher_round_engine
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      next,
    input  logic [1:0]                keylen,
    output logic [3:0]                round,
    input  logic [127:0]              round_key,
    output logic [32*SBOX_LANES-1:0]  sboxw,
    input  logic [32*SBOX_LANES-1:0]  new_sboxw,
    input  logic [127:0]              block,
    output logic [127:0]              new_block,
    output logic                      ready
);

    localparam int         c_sbox_cycles = 4 / SBOX_LANES;
    localparam logic [1:0] c_last_sword  = 2'(c_sbox_cycles - 1);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
        $error("aes_encipher_round_engine: SBOX_LANES must be 1, 2 or 4");
    end

    aes_state_t     r_state;
    logic [127:0]   r_block;
    logic           r_ready;
    logic [3:0]     r_round_ctr;
    logic [1:0]     r_sword_ctr;
    logic [1:0]     r_keylen;

    logic [31:0]    w_words     [4];
    logic [31:0]    w_sub_words [4];
    logic [1:0]     w_lane_idx  [SBOX_LANES];
    logic [127:0]   w_sub_block;
    logic [127:0]   w_sr_block;
    logic [127:0]   w_mix_block;
    logic [3:0]     w_nr;

    assign w_words[0] = r_block[127:96];
    assign w_words[1] = r_block[95:64];
    assign w_words[2] = r_block[63:32];
    assign w_words[3] = r_block[31:0];

    // Lane i of the S-box bus sits at bits [32i +: 32].
    for (genvar i = 0; i < SBOX_LANES; i++) begin : g_lane
        assign w_lane_idx[i] = 2'(int'(r_sword_ctr) * SBOX_LANES + i);
        assign sboxw[32*i +: 32] = (r_state == ST_SBOX) ? w_words[w_lane_idx[i]] : 32'h0;
    end

    always_comb begin
        for (int w = 0; w < 4; w++) begin
            w_sub_words[w] = w_words[w];
        end
        for (int i = 0; i < SBOX_LANES; i++) begin
            w_sub_words[w_lane_idx[i]] = new_sboxw[32*i +: 32];
        end
    end

    assign w_sub_block = {w_sub_words[0], w_sub_words[1], w_sub_words[2], w_sub_words[3]};
    assign w_sr_block  = shiftrows(r_block);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_mixcolumn_word u_mix (
            .i_col (w_sr_block[127 - 32*c -: 32]),
            .o_col (w_mix_block[127 - 32*c -: 32])
        );
    end

    assign w_nr = nr_of(r_keylen);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_block     <= '0;
            r_ready     <= 1'b1;
            r_round_ctr <= 4'd0;
            r_sword_ctr <= 2'd0;
            r_keylen    <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (next) begin
                        r_block     <= block ^ round_key;
                        r_keylen    <= keylen;
                        r_round_ctr <= 4'd1;
                        r_sword_ctr <= 2'd0;
                        r_ready     <= 1'b0;
                        r_state     <= ST_SBOX;
                    end
                end
                ST_SBOX: begin
                    r_block     <= w_sub_block;
                    r_sword_ctr <= r_sword_ctr + 2'd1;
                    if (r_sword_ctr == c_last_sword) begin
                        r_state <= (r_round_ctr < w_nr) ? ST_MAIN : ST_FINAL;
                    end
                end
                ST_MAIN: begin
                    r_block     <= w_mix_block ^ round_key;
                    r_round_ctr <= r_round_ctr + 4'd1;
                    r_sword_ctr <= 2'd0;
                    r_state     <= ST_SBOX;
                end
                ST_FINAL: begin
                    r_block     <= w_sr_block ^ round_key;
                    r_ready     <= 1'b1;
                    r_round_ctr <= 4'd0;
                    r_sword_ctr <= 2'd0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign round     = r_round_ctr;
    assign new_block = r_block;
    assign ready     = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_aes_encipher_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_encipher_round_engine
// Description : Three engines (1, 2, 4 lanes) run in lock-step against a
//               byte-level AES reference and cycle-level timing model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes_encipher_round_engine;

    logic         clk = 1'b0;
    logic         reset, next;
    logic [1:0]   keylen;
    logic [127:0] block;

    logic [7:0]   sbox_tab [256];
    logic [127:0] rk_mem   [16];
    int           n_checks = 0;
    int           n_errors = 0;
    bit           chk_en   = 1'b0;

    always #5 clk = ~clk;

    localparam logic [127:0] c_pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] c_k128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] c_k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] c_k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_ct192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] c_ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    // ---------------- DUT instances ----------------
    logic [3:0]   round1, round2, round4;
    logic [127:0] rk1, rk2, rk4, nb1, nb2, nb4;
    logic [31:0]  sbw1, nsbw1;
    logic [63:0]  sbw2, nsbw2;
    logic [127:0] sbw4, nsbw4;
    logic         rdy1, rdy2, rdy4;

    assign rk1 = rk_mem[round1];
    assign rk2 = rk_mem[round2];
    assign rk4 = rk_mem[round4];
    assign nsbw1 = sub_word(sbw1);
    assign nsbw2 = {sub_word(sbw2[63:32]), sub_word(sbw2[31:0])};
    assign nsbw4 = {sub_word(sbw4[127:96]), sub_word(sbw4[95:64]),
                    sub_word(sbw4[63:32]), sub_word(sbw4[31:0])};

    aes_encipher_round_engine #(.SBOX_LANES(1)) u_dut1 (
        .clk(clk), .reset(reset), .next(next), .keylen(keylen), .round(round1),
        .round_key(rk1), .sboxw(sbw1), .new_sboxw(nsbw1), .block(block),
        .new_block(nb1), .ready(rdy1));
    aes_encipher_round_engine #(.SBOX_LANES(2)) u_dut2 (
        .clk(clk), .reset(reset), .next(next), .keylen(keylen), .round(round2),
        .round_key(rk2), .sboxw(sbw2), .new_sboxw(nsbw2), .block(block),
        .new_block(nb2), .ready(rdy2));
    aes_encipher_round_engine #(.SBOX_LANES(4)) u_dut4 (
        .clk(clk), .reset(reset), .next(next), .keylen(keylen), .round(round4),
        .round_key(rk4), .sboxw(sbw4), .new_sboxw(nsbw4), .block(block),
        .new_block(nb4), .ready(rdy4));

    logic [3:0]   rnd [3];
    logic [127:0] sbw [3];
    logic [127:0] nb  [3];
    logic         rdy [3];
    int           lanes [3] = '{1, 2, 4};

    assign rnd[0] = round1;  assign rnd[1] = round2;  assign rnd[2] = round4;
    assign sbw[0] = {96'h0, sbw1};  assign sbw[1] = {64'h0, sbw2};  assign sbw[2] = sbw4;
    assign nb[0]  = nb1;     assign nb[1]  = nb2;     assign nb[2]  = nb4;
    assign rdy[0] = rdy1;    assign rdy[1] = rdy2;    assign rdy[2] = rdy4;

    // ---------------- reference helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic int nr_of(input logic [1:0] kl);
        return (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    // Plays the role of the core's key memory: full schedule for nk key words.
    task automatic load_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- behavioural model ----------------
    logic [127:0] mst [3][15];
    bit           m_busy [3];
    int           m_k    [3];
    int           m_nr   [3];
    logic [127:0] m_exp  [3];

    // Byte-array AES; mst[d][r] is the state after round r (index 0 = initial AddRoundKey).
    task automatic model_run(input int d, input logic [127:0] pt, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk_mem[0][127 - 8*i -: 8];
        for (int i = 0; i < 16; i++) mst[d][0][127 - 8*i -: 8] = s[i];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[rr + 4*c] = s[rr + 4*((c + rr) % 4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < nr) begin
                    s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_mem[r][127 - 8*i -: 8];
            for (int i = 0; i < 16; i++) mst[d][r][127 - 8*i -: 8] = s[i];
        end
    endtask

    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_busy[d] = 1'b0;
                m_k[d]    = 0;
                m_exp[d]  = '0;
            end else if (!m_busy[d]) begin
                if (next) begin
                    m_busy[d] = 1'b1;
                    m_k[d]    = 0;
                    m_nr[d]   = nr_of(keylen);
                    model_run(d, block, m_nr[d]);
                end
            end else begin
                m_k[d] = m_k[d] + 1;
                if (m_k[d] == m_nr[d] * (4 / lanes[d] + 1)) begin
                    m_busy[d] = 1'b0;
                    m_exp[d]  = mst[d][m_nr[d]];
                end
            end
        end
    end

    task automatic check(input string name, input int d, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    // Per-cycle compare: each round spans (4/lanes) SubBytes cycles plus one MAIN/FINAL cycle.
    initial begin
        int c, p, r;
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 3; d++) begin
                    c = 4 / lanes[d] + 1;
                    check("ready", d, 128'(rdy[d]), 128'(!m_busy[d]));
                    if (!m_busy[d]) begin
                        check("round_idle", d, 128'(rnd[d]), 128'h0);
                        check("sboxw_idle", d, sbw[d], 128'h0);
                        check("new_block_idle", d, nb[d], m_exp[d]);
                    end else begin
                        p = m_k[d] % c;
                        r = 1 + m_k[d] / c;
                        check("round", d, 128'(rnd[d]), 128'(r));
                        e = '0;
                        if (p < c - 1)
                            for (int i = 0; i < lanes[d]; i++)
                                e[32*i +: 32] = mst[d][r-1][127 - 32*(p*lanes[d] + i) -: 32];
                        check("sboxw", d, sbw[d], e);
                        if (p == 0) check("round_state", d, nb[d], mst[d][r-1]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_all_ready();
        for (int n = 0; n < 300; n++) begin
            if (rdy[0] && rdy[1] && rdy[2]) return;
            tick();
        end
        check("idle_timeout", -1, 128'(rdy[0] && rdy[1] && rdy[2]), 128'h1);
    endtask

    task automatic do_run(input logic [127:0] pt, input logic [1:0] kl,
                          input int l0, input int l1, input int l2, input bit disturb);
        int seen [3];
        int el   [3];
        el = '{l0, l1, l2};
        seen = '{0, 0, 0};
        block = pt; keylen = kl; next = 1'b1;
        tick();
        next = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (disturb && n == 7) begin
                next = 1'b1; block = ~pt; keylen = kl + 2'd1;
            end
            if (disturb && n == 8) next = 1'b0;
            tick();
            for (int d = 0; d < 3; d++) if (seen[d] == 0 && rdy[d]) seen[d] = n;
            if (seen[0] != 0 && seen[1] != 0 && seen[2] != 0) break;
        end
        for (int d = 0; d < 3; d++) check("latency", d, 128'(seen[d]), 128'(el[d]));
        wait_all_ready();
    endtask

    task automatic check_ct(input logic [127:0] ct, input int nr);
        for (int d = 0; d < 3; d++) begin
            check("ciphertext", d, nb[d], ct);
            check("model_ct", d, mst[d][nr], ct);
        end
    endtask

    initial begin
        int r1 [3];
        int r2 [3];
        bit prev [3];
        logic [255:0] key;
        logic [1:0]   kl;
        int           nr, got;

        reset = 1'b1; next = 1'b0; keylen = 2'd0; block = '0;
        build_sbox();
        check("sbox_00", -1, 128'(sbox_tab[8'h00]), 128'h63);
        check("sbox_53", -1, 128'(sbox_tab[8'h53]), 128'hed);
        load_key(c_k128, 4);
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            check("reset_ready", d, 128'(rdy[d]), 128'h1);
            check("reset_block", d, nb[d], 128'h0);
            check("reset_round", d, 128'(rnd[d]), 128'h0);
        end
        reset = 1'b0;
        chk_en = 1'b1;
        tick();

        do_run(c_pt, 2'd0, 50, 30, 20, 1'b0);
        check_ct(c_ct128, 10);
        load_key(c_k192, 6);
        do_run(c_pt, 2'd1, 60, 36, 24, 1'b0);
        check_ct(c_ct192, 12);
        load_key(c_k256, 8);
        do_run(c_pt, 2'd2, 70, 42, 28, 1'b0);
        check_ct(c_ct256, 14);

        // Busy handling: next pulse plus block/keylen changes mid-run.
        load_key(c_k128, 4);
        do_run(c_pt, 2'd0, 50, 30, 20, 1'b1);
        check_ct(c_ct128, 10);

        // Reset in round 5 of the single-lane engine.
        block = c_pt; keylen = 2'd0; next = 1'b1;
        tick();
        next = 1'b0;
        got = 0;
        for (int n = 0; n < 100; n++) begin
            if (rnd[0] == 4'd5) begin got = 1; break; end
            tick();
        end
        check("reach_round5", 0, 128'(got), 128'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("abort_ready", d, 128'(rdy[d]), 128'h1);
            check("abort_block", d, nb[d], 128'h0);
            check("abort_round", d, 128'(rnd[d]), 128'h0);
        end
        tick();
        do_run(c_pt, 2'd0, 50, 30, 20, 1'b0);
        check_ct(c_ct128, 10);

        // Back-to-back with reserved keylen: next held high across completion.
        r1 = '{0, 0, 0}; r2 = '{0, 0, 0}; prev = '{0, 0, 0};
        block = c_pt; keylen = 2'd3; next = 1'b1;
        tick();
        for (int n = 1; n <= 260; n++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                if (rdy[d] && !prev[d]) begin
                    if (r1[d] == 0) begin
                        r1[d] = n;
                        check("b2b_ct1", d, nb[d], c_ct128);
                    end else if (r2[d] == 0) begin
                        r2[d] = n;
                        check("b2b_ct2", d, nb[d], c_ct128);
                    end
                end
                prev[d] = rdy[d];
            end
            if (r2[0] != 0) break;
        end
        next = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("b2b_first", d, 128'(r1[d]), 128'(10 * (4 / lanes[d] + 1)));
            check("b2b_second", d, 128'(r2[d]), 128'(20 * (4 / lanes[d] + 1) + 1));
        end
        wait_all_ready();

        // Randomised runs against the reference.
        for (int it = 0; it < 8; it++) begin
            kl  = 2'($urandom_range(0, 3));
            nr  = nr_of(kl);
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            load_key(key, nr - 6);
            do_run({$urandom(), $urandom(), $urandom(), $urandom()}, kl,
                   nr * 5, nr * 3, nr * 2, 1'($urandom_range(0, 1)));
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/aes_encipher_round_engine.md
Name: aes_encipher_round_engine

Overview:
- Iterative AES block encipher engine, generalised successor of the single-lane encipher round logic.
- Supports AES-128, AES-192 and AES-256 (runtime keylen).
- Parametrised S-box lane count trades area against latency.
- Sits between the core control/key-memory and the shared external S-box array.
- Requests round keys by index and S-box substitutions by word.
- Produces the ciphertext block and a ready flag.

Parameters:
- SBOX_LANES, default 1: 32-bit words substituted per cycle. Legal values 1, 2, 4; any other value is an elaboration error.
- SBOX_CYCLES, derived = 4/SBOX_LANES: SubBytes cycles per round. Not overridable.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- next  in  1  start pulse; sampled only while ready=1.
- keylen  in  2  key length: 0=128, 1=192, 2=256, 3=reserved (treated as 128). Sampled on start.
- round  out  4  round-key index requested. Combinational from the round counter; 0 while idle.
- round_key  in  128  key for index round; must be valid in the same cycle (combinational key memory).
- sboxw  out  32*SBOX_LANES  words to substitute. Lane i holds state word (sword_ctr*SBOX_LANES+i).
- new_sboxw  in  32*SBOX_LANES  substituted words; combinational return in the same cycle.
- block  in  128  plaintext; sampled on start.
- new_block  out  128  state register, {w0,w1,w2,w3}. Holds the ciphertext when ready=1 after a run.
- ready  out  1  high when idle or done.

Behaviour:
- Reset values: ready=1, new_block=0, round=0, sboxw=0, FSM=IDLE, all counters 0, latched keylen=0.
- Reset mid-operation aborts the run immediately. The next cycle shows reset values.
- Nr = 10/12/14 for keylen 0/1/2 (reserved 3 gives 10). Nr is derived from the latched keylen only.
- FSM states:
  - IDLE: on next=1, state <= block ^ round_key (key 0); latch keylen; round_ctr <= 1; sword_ctr <= 0; ready <= 0; go to SBOX.
  - next=0 in IDLE: hold everything.
  - SBOX: for each lane, write the state word at index sword_ctr*SBOX_LANES+lane with new_sboxw. Increment sword_ctr. On the last SBOX_CYCLES cycle go to MAIN if round_ctr<Nr, else FINAL.
  - MAIN: state <= MixColumns(ShiftRows(state)) ^ round_key. round_ctr++; sword_ctr <= 0; go to SBOX.
  - FINAL: state <= ShiftRows(state) ^ round_key. ready <= 1; round_ctr <= 0; go to IDLE.
- ShiftRows and MixColumns follow FIPS-197 exactly, with byte 0 = block[127:120] and column-major state.
- sboxw is 0 outside SBOX.
- SubBytes writes only the addressed words; all other state words hold.
- Latency: ready falls the cycle after the start edge and rises Nr*(SBOX_CYCLES+1) cycles after the start edge.
  - AES-128: lanes1 = 50, lanes2 = 30, lanes4 = 20.
  - AES-256 lanes1 = 70.
- next while ready=0 is ignored. Changes to keylen or block during a run have no effect.
- next held high across completion starts a new run on the first cycle ready=1 is sampled. Back-to-back runs have no dead cycle beyond that.
- Counters: sword_ctr is 2 bits and wraps per round; round_ctr is 4 bits and never exceeds 14.
- new_block is stable from the FINAL edge until the next start.

Decomposition:
- Shared package aes_pkg:
  - keylen codes and Nr constants.
  - FSM state encodings.
  - gm2/gm3 GF(2^8) functions.
  - shiftrows function on 128 bits.
- One sub-module, aes_mixcolumn_word: combinational 32-bit column MixColumns, instantiated 4 times.

Test Plan:
- FIPS-197 C.1 case: AES-128, key 000102..0f, pt 00112233445566778899aabbccddeeff, lanes=1. Response: ct 69c4e0d86a7b0430d8cdb78070b4c55a; ready rises exactly 50 cycles after the start edge. Bench supplies the reference key schedule and S-box.
- FIPS-197 C.2/C.3 cases: AES-192 key 00..17 gives dda97ca4864cdfe06eaf70a0ec0d7191; AES-256 key 00..1f gives 8ea2b7ca516745bfeafc49904b496089. Run at SBOX_LANES 1, 2, 4; latencies 60/36/24 and 70/42/28 respectively.
- Busy handling: pulse next and change block/keylen mid-run. Ciphertext unchanged, no restart, round sequence monotonic 1..Nr.
- Reset mid-run: assert reset at round 5 for 1 cycle. Next cycle ready=1, new_block=0, round=0; a fresh run then gives the correct ciphertext.
- Back-to-back and reserved keylen: hold next=1 over two runs with keylen=3. Second run starts the cycle ready is seen high; both use Nr=10 and match the AES-128 result.
